// File: rtl/rubik_io_pkg.sv
// Shared encodings for the software <-> hardware face/move link.
// Handshake codes, receive FSM states and default widths.
package rubik_io_pkg;

  localparam int WIDTH_DEF = 30;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] SIG_IDLE       = 2'd0;
  localparam logic [1:0] SIG_DATA       = 2'd1;
  localparam logic [1:0] SIG_ACK        = 2'd2;
  localparam logic [1:0] SIG_START_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RDY  = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rubik_move_rx_if.sv
// Software handshake plus downstream valid/ready stream.
// master = software/consumer side, slave = receiver.
interface rubik_move_rx_if
  import rubik_io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [1:0]       to_hw_sig;
  logic [WIDTH-1:0] to_hw_port;
  logic [1:0]       to_sw_sig;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output to_hw_sig,
    output to_hw_port,
    output out_ready,
    input  to_sw_sig,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  to_hw_sig,
    input  to_hw_port,
    input  out_ready,
    output to_sw_sig,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, occupancy counter.
// Pointers wrap naturally; count separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rubik_move_rx.sv
// Receives a software move sequence over the 2-bit/port handshake
// and buffers each word for the downstream executor.
module rubik_move_rx
  import rubik_io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 16,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  rubik_move_rx_if.slave         io,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   busy,
  output logic                   done_pulse
);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_pulse_q, done_pulse_d;
  logic             wr_en, rd_en;
  logic             full, empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .wr_en   (wr_en),
    .wr_data (io.to_hw_port),
    .rd_en   (rd_en),
    .rd_data (io.out_data),
    .full    (full),
    .empty   (empty),
    .count   (fill)
  );

  assign io.out_valid = !empty;
  assign rd_en        = !empty && io.out_ready;
  assign busy         = (state_q != ST_IDLE);
  assign done_pulse   = done_pulse_q;

  // Handshake FSM next-state, word write and remaining count
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wr_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (io.to_hw_sig == SIG_START_DONE) begin
          remaining_d = io.to_hw_port[CNT_W-1:0];
          state_d = (remaining_d == '0) ? ST_DONE : ST_RDY;
        end
      end
      ST_RDY: begin
        if (io.to_hw_sig == SIG_DATA && !full) begin
          wr_en   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (io.to_hw_sig == SIG_IDLE) begin
          remaining_d = remaining_q - CNT_W'(1);
          state_d = (remaining_d == '0) ? ST_DONE : ST_RDY;
        end
      end
      ST_DONE: begin
        if (io.to_hw_sig == SIG_IDLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_pulse_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Response code from registered state; RDY stalls while full
  always_comb begin
    io.to_sw_sig = SIG_IDLE;
    unique case (state_q)
      ST_IDLE: io.to_sw_sig = SIG_IDLE;
      ST_RDY:  io.to_sw_sig = full ? SIG_IDLE : SIG_DATA;
      ST_ACK:  io.to_sw_sig = SIG_ACK;
      ST_DONE: io.to_sw_sig = SIG_START_DONE;
      default: io.to_sw_sig = SIG_IDLE;
    endcase
  end

  // State, counter and done pulse registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      done_pulse_q <= done_pulse_d;
    end
  end

endmodule

// File: tb/tb_rubik_move_rx.sv
// Bench for rubik_move_rx: transfer-level model plus directed
// scenarios and randomized transfers with random back-pressure.
module tb_rubik_move_rx;
  import rubik_io_pkg::*;

  localparam int WIDTH = 30;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] fill;
  logic          busy;
  logic          done_pulse;

  rubik_move_rx_if #(.WIDTH(WIDTH)) ifc();

  rubik_move_rx #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .io         (ifc),
    .fill       (fill),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transfer-level model: a queue of buffered words and the
  // software-visible progress of the current transfer.
  logic [WIDTH-1:0] mq[$];
  bit               m_active, m_pend, m_fin, m_first;
  int               m_left;
  bit               m_ok = 1'b0;
  bit               pop_m, push_m;
  logic [WIDTH-1:0] w_m;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_active = 0; m_pend = 0; m_fin = 0; m_first = 0;
        m_left = 0;
        m_ok = 1'b1;
      end else begin
        pop_m  = (mq.size() > 0) && ifc.out_ready;
        push_m = 0;
        w_m    = ifc.to_hw_port;
        m_first = 0;
        if (m_fin) begin
          if (ifc.to_hw_sig == 2'd0) m_fin = 0;
        end else if (!m_active) begin
          if (ifc.to_hw_sig == 2'd3) begin
            m_left = int'(ifc.to_hw_port[CNT_W-1:0]);
            if (m_left == 0) begin
              m_fin = 1; m_first = 1;
            end else m_active = 1;
          end
        end else if (m_pend) begin
          if (ifc.to_hw_sig == 2'd0) begin
            m_pend = 0;
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_active = 0; m_fin = 1; m_first = 1;
            end
          end
        end else if (ifc.to_hw_sig == 2'd1 &&
                     mq.size() < DEPTH) begin
          push_m = 1;
          m_pend = 1;
        end
        if (pop_m) void'(mq.pop_front());
        if (push_m) mq.push_back(w_m);
      end
    end
  end

  // Every-cycle comparison against the model
  logic [1:0] exp_sw;
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        if (m_fin) exp_sw = 2'd3;
        else if (!m_active) exp_sw = 2'd0;
        else if (m_pend) exp_sw = 2'd2;
        else exp_sw = (mq.size() < DEPTH) ? 2'd1 : 2'd0;
        chk("to_sw_sig", 32'(ifc.to_sw_sig), 32'(exp_sw));
        chk("fill", 32'(fill), 32'(mq.size()));
        chk("out_valid", 32'(ifc.out_valid), 32'(mq.size() > 0));
        chk("busy", 32'(busy), 32'(m_active || m_fin));
        chk("done_pulse", 32'(done_pulse), 32'(m_first));
        if (mq.size() > 0)
          chk("out_data", 32'(ifc.out_data), 32'(mq[0]));
      end
    end
  end

  // Observation of response sequence, done pulses and pops
  bit               rec = 1'b0;
  logic [1:0]       seq[$];
  logic [1:0]       last_sw = 2'd0;
  int               done_cnt = 0;
  logic [WIDTH-1:0] popped[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rec) begin
        if (ifc.to_sw_sig != last_sw) seq.push_back(ifc.to_sw_sig);
        last_sw = ifc.to_sw_sig;
        if (done_pulse) done_cnt++;
      end
      if (ifc.out_valid && ifc.out_ready)
        popped.push_back(ifc.out_data);
    end
  end

  // Random back-pressure when enabled
  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_sw(input logic [1:0] v, input string nm);
    int n = 0;
    while (ifc.to_sw_sig !== v && n < 300) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 300) begin
      errors++;
      $display("FAIL timeout %s: to_sw_sig %0d expected %0d",
               nm, ifc.to_sw_sig, v);
    end
  endtask

  task automatic start(input int n);
    ifc.to_hw_sig  = 2'd3;
    ifc.to_hw_port = WIDTH'(n);
    step();
    ifc.to_hw_sig = 2'd0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int hold);
    wait_sw(2'd1, "ready_for_word");
    ifc.to_hw_sig  = 2'd1;
    ifc.to_hw_port = w;
    step();
    wait_sw(2'd2, "ack");
    repeat (hold) step();
    ifc.to_hw_sig = 2'd0;
    step();
  endtask

  task automatic finish_xfer();
    wait_sw(2'd3, "done");
    step();
  endtask

  task automatic xfer(input int n);
    start(n);
    for (int i = 0; i < n; i++)
      send_word(WIDTH'($urandom), $urandom_range(0, 3));
    finish_xfer();
  endtask

  logic [WIDTH-1:0] t1_words[3];
  logic [1:0]       t1_seq[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t1_words[0] = 30'h1;
    t1_words[1] = 30'h2;
    t1_words[2] = 30'h3000_0003;
    t1_seq[0] = 2'd1; t1_seq[1] = 2'd2; t1_seq[2] = 2'd1;
    t1_seq[3] = 2'd2; t1_seq[4] = 2'd1; t1_seq[5] = 2'd2;
    t1_seq[6] = 2'd3; t1_seq[7] = 2'd0;

    ifc.to_hw_sig  = 2'd0;
    ifc.to_hw_port = '0;
    ifc.out_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst_sw", 32'(ifc.to_sw_sig), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);

    // Basic three-word transfer
    ifc.out_ready = 1'b1;
    popped.delete(); seq.delete();
    last_sw = 2'd0; done_cnt = 0; rec = 1'b1;
    start(3);
    for (int i = 0; i < 3; i++) send_word(t1_words[i], 0);
    finish_xfer();
    step();
    rec = 1'b0;
    chk("t1_seq_len", 32'(seq.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < seq.size())
        chk("t1_seq", 32'(seq[i]), 32'(t1_seq[i]));
    chk("t1_npop", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < popped.size())
        chk("t1_word", 32'(popped[i]), 32'(t1_words[i]));
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Zero-length transfer
    done_cnt = 0; rec = 1'b1;
    start(0);
    chk("n0_sw", 32'(ifc.to_sw_sig), 32'd3);
    chk("n0_done", 32'(done_pulse), 32'd1);
    chk("n0_fill", 32'(fill), 32'd0);
    step();
    rec = 1'b0;
    chk("n0_idle", 32'(ifc.to_sw_sig), 32'd0);
    chk("n0_done_cnt", 32'(done_cnt), 32'd1);

    // Fill to DEPTH with consumer stalled, then release
    ifc.out_ready = 1'b0;
    popped.delete();
    start(20);
    for (int i = 0; i < 16; i++) send_word(WIDTH'(100 + i), 0);
    chk("full_fill", 32'(fill), 32'd16);
    chk("full_sw", 32'(ifc.to_sw_sig), 32'd0);
    step();
    chk("full_sw_hold", 32'(ifc.to_sw_sig), 32'd0);
    ifc.out_ready = 1'b1;
    step();
    chk("unstall_fill", 32'(fill), 32'd15);
    chk("unstall_sw", 32'(ifc.to_sw_sig), 32'd1);
    for (int i = 16; i < 20; i++) send_word(WIDTH'(100 + i), 0);
    finish_xfer();
    repeat (DEPTH + 4) step();
    chk("full_npop", 32'(popped.size()), 32'd20);
    for (int i = 0; i < 20; i++)
      if (i < popped.size())
        chk("full_order", 32'(popped[i]), 32'(100 + i));

    // Held data command writes once
    ifc.out_ready = 1'b0;
    start(1);
    wait_sw(2'd1, "hold_rdy");
    ifc.to_hw_sig  = 2'd1;
    ifc.to_hw_port = 30'h2AA;
    repeat (10) step();
    chk("hold_fill", 32'(fill), 32'd1);
    chk("hold_sw", 32'(ifc.to_sw_sig), 32'd2);
    ifc.to_hw_sig = 2'd0;
    step();
    chk("hold_done", 32'(ifc.to_sw_sig), 32'd3);
    step();
    ifc.out_ready = 1'b1;
    repeat (3) step();
    chk("hold_drain", 32'(fill), 32'd0);

    // Reset in the middle of a transfer
    ifc.out_ready = 1'b0;
    start(5);
    send_word(30'h11, 0);
    send_word(30'h22, 0);
    chk("mid_fill", 32'(fill), 32'd2);
    rst_n = 1'b0;
    step();
    chk("mrst_sw", 32'(ifc.to_sw_sig), 32'd0);
    chk("mrst_valid", 32'(ifc.out_valid), 32'd0);
    chk("mrst_fill", 32'(fill), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    start(1);
    send_word(30'h55, 0);
    chk("mrst_again_sw", 32'(ifc.to_sw_sig), 32'd3);
    chk("mrst_again_done", 32'(done_pulse), 32'd1);
    chk("mrst_again_fill", 32'(fill), 32'd1);
    step();
    ifc.out_ready = 1'b1;
    repeat (3) step();

    // Simultaneous pop and write at fill 7
    ifc.out_ready = 1'b0;
    start(10);
    for (int i = 0; i < 7; i++) send_word(WIDTH'(200 + i), 0);
    wait_sw(2'd1, "sim_rdy");
    chk("sim_pre_fill", 32'(fill), 32'd7);
    ifc.to_hw_sig  = 2'd1;
    ifc.to_hw_port = 30'h777;
    ifc.out_ready  = 1'b1;
    step();
    ifc.out_ready = 1'b0;
    chk("sim_fill", 32'(fill), 32'd7);
    wait_sw(2'd2, "sim_ack");
    ifc.to_hw_sig = 2'd0;
    step();
    ifc.out_ready = 1'b1;
    send_word(30'h888, 1);
    send_word(30'h999, 2);
    finish_xfer();
    repeat (12) step();
    chk("sim_drain", 32'(fill), 32'd0);

    // Randomized transfers with back-pressure, incl. wrap
    rand_ready = 1'b1;
    xfer(40);
    for (int t = 0; t < 8; t++) begin
      ifc.to_hw_sig = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0;
      repeat ($urandom_range(0, 3)) step();
      ifc.to_hw_sig = 2'd0;
      step();
      xfer($urandom_range(0, 40));
    end
    rand_ready = 1'b0;
    step();
    ifc.out_ready = 1'b1;
    repeat (DEPTH + 4) step();
    chk("final_fill", 32'(fill), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
